// File: rtl/dso_pkg.sv
// Shared definitions for the sample-capture path: RAM geometry, capture states,
// trigger select/edge encodings and the decimation mask helper.
package dso_pkg;

   localparam int ADDR_W = 9;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMING,
      ST_ARMED,
      ST_TRIGGERED,
      ST_DONE
   } state_t;

   localparam logic TRIG_SRC_1 = 1'b0;
   localparam logic TRIG_SRC_2 = 1'b1;
   localparam logic EDGE_FALL  = 1'b0;
   localparam logic EDGE_RISE  = 1'b1;

   // Low `d` bits of the 4-bit decimation counter; saturates at all four bits.
   function automatic logic [3:0] dec_mask(input logic [3:0] d);
      case (d)
         4'd0:    return 4'h0;
         4'd1:    return 4'h1;
         4'd2:    return 4'h3;
         4'd3:    return 4'h7;
         default: return 4'hF;
      endcase
   endfunction

endpackage

// File: rtl/trig_detect.sv
// Trigger front end: two-flop synchronizers on both comparator inputs, source
// mux and a registered edge detector (async edge to trig_evt is 3 clk).
module trig_detect
   import dso_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic trig1,
   input  logic trig2,
   input  logic trig_src,
   input  logic trig_edge,
   output logic trig_evt
);

   logic [1:0] trig_in;
   logic [1:0] trig_sync;
   logic       trig_sel;
   logic       prev_reg;
   logic       trig_evt_reg;

   assign trig_in = {trig2, trig1};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_reg <= 1'b0;
               s2_reg <= 1'b0;
            end else begin
               s1_reg <= trig_in[gi];
               s2_reg <= s1_reg;
            end
         end
         assign trig_sync[gi] = s2_reg;
      end
   endgenerate

   assign trig_sel = (trig_src == TRIG_SRC_2) ? trig_sync[1] : trig_sync[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg     <= 1'b0;
         trig_evt_reg <= 1'b0;
      end else begin
         prev_reg     <= trig_sel;
         trig_evt_reg <= (trig_edge == EDGE_RISE) ? (trig_sel & ~prev_reg)
                                                  : (~trig_sel & prev_reg);
      end
   end

   assign trig_evt = trig_evt_reg;

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: ADC/RAM clock generation, circular pre-trigger buffer,
// post-trigger countdown and the shared RAM port used by the dump logic.
module capture_ctrl
   import dso_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              force_trig,
   input  logic              trig1,
   input  logic              trig2,
   input  logic              trig_src,
   input  logic              trig_edge,
   input  logic [ADDR_W-1:0] trig_pos,
   input  logic [3:0]        decimator,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              adc_clk,
   output logic              rclk,
   output logic              en,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              capture_done,
   output logic [ADDR_W-1:0] trace_end
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   state_t            state_reg, state_next;
   logic              adc_clk_reg, adc_clk_next;
   logic              rclk_reg, rclk_next;
   logic              en_reg, en_next;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W-1:0] trace_end_reg, trace_end_next;
   logic [ADDR_W-1:0] wptr_reg, wptr_next;
   logic [ADDR_W:0]   pre_cnt_reg, pre_cnt_next;
   logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;
   logic [3:0]        dec_cnt_reg, dec_cnt_next;

   logic              trig_evt;
   logic              tick;
   logic              write_tick;
   logic              capturing;
   logic              finishing;
   logic [ADDR_W:0]   pre_target;

   trig_detect u_trig_detect (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig1     (trig1),
      .trig2     (trig2),
      .trig_src  (trig_src),
      .trig_edge (trig_edge),
      .trig_evt  (trig_evt)
   );

   // A tick is the clk edge on which adc_clk rises.
   assign tick       = ~adc_clk_reg;
   assign write_tick = tick && ((dec_cnt_reg & dec_mask(decimator)) == 4'd0);
   assign capturing  = (state_reg == ST_ARMING) || (state_reg == ST_ARMED) ||
                       (state_reg == ST_TRIGGERED);
   // The final post-trigger write is held for a full ADC period before DONE.
   assign finishing  = (state_reg == ST_TRIGGERED) && tick && (post_cnt_reg == '0);
   assign pre_target = DEPTH_CNT - {1'b0, trig_pos};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         adc_clk_reg   <= 1'b0;
         rclk_reg      <= 1'b1;
         en_reg        <= 1'b0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         trace_end_reg <= '0;
         wptr_reg      <= '0;
         pre_cnt_reg   <= '0;
         post_cnt_reg  <= '0;
         dec_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         adc_clk_reg   <= adc_clk_next;
         rclk_reg      <= rclk_next;
         en_reg        <= en_next;
         we_reg        <= we_next;
         addr_reg      <= addr_next;
         trace_end_reg <= trace_end_next;
         wptr_reg      <= wptr_next;
         pre_cnt_reg   <= pre_cnt_next;
         post_cnt_reg  <= post_cnt_next;
         dec_cnt_reg   <= dec_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      adc_clk_next   = ~adc_clk_reg;
      rclk_next      = ~adc_clk_reg;
      en_next        = en_reg;
      we_next        = we_reg;
      addr_next      = addr_reg;
      trace_end_next = trace_end_reg;
      wptr_next      = wptr_reg;
      pre_cnt_next   = pre_cnt_reg;
      post_cnt_next  = post_cnt_reg;
      dec_cnt_next   = dec_cnt_reg;

      if (abort) begin
         state_next = ST_IDLE;
         en_next    = 1'b0;
         we_next    = 1'b0;
      end else begin
         if (capturing && !finishing) begin
            if (tick) begin
               dec_cnt_next = dec_cnt_reg + 4'd1;
               en_next      = write_tick;
               we_next      = write_tick;
            end
            if (write_tick) begin
               addr_next = wptr_reg;
               wptr_next = wptr_reg + 1'b1;
            end
         end

         case (state_reg)
            ST_IDLE, ST_DONE: begin
               en_next   = rd_en;
               we_next   = 1'b0;
               addr_next = rd_addr;
               if (start) begin
                  state_next   = ST_ARMING;
                  wptr_next    = '0;
                  pre_cnt_next = '0;
                  dec_cnt_next = '0;
                  en_next      = 1'b0;
                  addr_next    = addr_reg;
               end
            end
            ST_ARMING: begin
               if (write_tick) begin
                  pre_cnt_next = pre_cnt_reg + 1'b1;
                  if (pre_cnt_next >= pre_target) begin
                     state_next = ST_ARMED;
                  end
               end
            end
            ST_ARMED: begin
               if (trig_evt || force_trig) begin
                  post_cnt_next = trig_pos;
                  state_next    = ST_TRIGGERED;
               end
            end
            ST_TRIGGERED: begin
               if (finishing) begin
                  state_next     = ST_DONE;
                  en_next        = 1'b0;
                  we_next        = 1'b0;
                  trace_end_next = addr_reg;
               end else if (write_tick) begin
                  post_cnt_next = post_cnt_reg - 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign adc_clk      = adc_clk_reg;
   assign rclk         = rclk_reg;
   assign en           = en_reg;
   assign we           = we_reg;
   assign addr         = addr_reg;
   assign trace_end    = trace_end_reg;
   assign busy         = capturing;
   assign capture_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: stimulus queues the expected RAM writes
// (address and clk edge), a monitor pops one per observed write.
module tb_capture_ctrl;
   import dso_pkg::*;

   typedef struct {
      int addr;
      int edge_no;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              force_trig = 1'b0;
   logic              trig1 = 1'b0;
   logic              trig2 = 1'b0;
   logic              trig_src = 1'b0;
   logic              trig_edge = 1'b1;
   logic [ADDR_W-1:0] trig_pos = '0;
   logic [3:0]        decimator = '0;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              adc_clk, rclk, en, we, busy, capture_done;
   logic [ADDR_W-1:0] addr, trace_end;

   int  checks = 0;
   int  failures = 0;
   int  edge_n = 0;
   int  s;
   wr_t exp_q[$];

   capture_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .force_trig   (force_trig),
      .trig1        (trig1),
      .trig2        (trig2),
      .trig_src     (trig_src),
      .trig_edge    (trig_edge),
      .trig_pos     (trig_pos),
      .decimator    (decimator),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .adc_clk      (adc_clk),
      .rclk         (rclk),
      .en           (en),
      .we           (we),
      .addr         (addr),
      .busy         (busy),
      .capture_done (capture_done),
      .trace_end    (trace_end)
   );

   always #5 clk = ~clk;

   // Count posedges since reset release; odd edges are ADC ticks.
   initial forever begin
      @(posedge clk);
      if (rst_n) edge_n++;
   end

   // Monitor: a new write is en&we with a fresh address (or a rising en&we).
   initial begin
      logic              prev_w;
      logic [ADDR_W-1:0] prev_addr;
      wr_t               e;
      prev_w    = 1'b0;
      prev_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         if (en && we && (!prev_w || addr != prev_addr)) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write: actual addr=%0d edge=%0d required none", addr, edge_n);
            end else begin
               e = exp_q.pop_front();
               if (int'(addr) != e.addr || edge_n != e.edge_no) begin
                  failures++;
                  $display("FAIL write: actual addr=%0d edge=%0d required addr=%0d edge=%0d",
                           addr, edge_n, e.addr, e.edge_no);
               end else begin
                  $display("WR addr=%0d edge=%0d ok", addr, edge_n);
               end
            end
         end
         prev_w    = en && we;
         prev_addr = addr;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic wait_neg(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   // Write k (1-based) of a capture started on edge s lands on the tick where
   // the decimation counter is (k-1)*2**d.
   task automatic push_wr(input int st, input int d, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         exp_q.push_back('{addr: (k - 1) % DEPTH, edge_no: st + (k - 1) * (2 << d) + 1});
      end
   endtask

   // Start is sampled on an even (non-tick) edge; returns that edge number.
   task automatic do_start(output int st);
      @(negedge clk);
      while (edge_n % 2 == 0) @(negedge clk);
      start = 1'b1;
      st = edge_n + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_adc_clk", int'(adc_clk), 0);
      check("rst_rclk", int'(rclk), 1);
      check("rst_en", int'(en), 0);
      check("rst_we", int'(we), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(capture_done), 0);
      check("rst_trace_end", int'(trace_end), 0);
      rst_n = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         wait_neg(n);
         check("adc_clk_toggle", int'(adc_clk), n % 2);
         check("rclk_follow", int'(rclk), n % 2);
         check("idle_en", int'(en), 0);
         check("idle_addr", int'(addr), 0);
      end

      // trig1 rising after 300 writes, 256 post-trigger samples
      trig_pos = 9'd256;
      decimator = 4'd0;
      do_start(s);
      push_wr(s, 0, 1, 558);
      wait_neg(s + 1);
      check("t2_busy", int'(busy), 1);
      wait_neg(s + 599);
      trig1 = 1'b1;
      wait_neg(s + 1116);
      check("t2_done_early", int'(capture_done), 0);
      wait_neg(s + 1117);
      check("t2_done", int'(capture_done), 1);
      check("t2_busy_clear", int'(busy), 0);
      check("t2_trace_end", int'(trace_end), 45);
      wait_neg(s + 1140);
      check("t2_writes_left", exp_q.size(), 0);
      trig1 = 1'b0;

      // early trig1 pulse ignored in ARMING, force_trig at write 400
      do_start(s);
      push_wr(s, 0, 1, 656);
      wait_neg(s + 199);
      trig1 = 1'b1;
      wait_neg(s + 203);
      trig1 = 1'b0;
      wait_neg(s + 799);
      force_trig = 1'b1;
      wait_neg(s + 800);
      force_trig = 1'b0;
      wait_neg(s + 1312);
      check("t3_done_early", int'(capture_done), 0);
      wait_neg(s + 1313);
      check("t3_done", int'(capture_done), 1);
      check("t3_trace_end", int'(trace_end), 143);
      wait_neg(s + 1330);
      check("t3_writes_left", exp_q.size(), 0);

      // decimator=2: one write every 4 ADC periods, then abort in ARMED
      decimator = 4'd2;
      trig_pos = 9'd509;
      do_start(s);
      push_wr(s, 2, 1, 3);
      wait_neg(s + 2);
      check("t4_en_held", int'(en), 1);
      wait_neg(s + 3);
      check("t4_en_skip", int'(en), 0);
      wait_neg(s + 20);
      abort = 1'b1;
      wait_neg(s + 21);
      abort = 1'b0;
      check("t4_abort_busy", int'(busy), 0);
      check("t4_abort_en", int'(en), 0);
      check("t4_trace_end_kept", int'(trace_end), 143);
      check("t4_writes_left", exp_q.size(), 0);

      // trig_pos=0 with falling trig2
      decimator = 4'd0;
      trig_pos = 9'd0;
      trig_src = 1'b1;
      trig_edge = 1'b0;
      trig2 = 1'b1;
      repeat (5) @(negedge clk);
      do_start(s);
      push_wr(s, 0, 1, 517);
      wait_neg(s + 1029);
      trig2 = 1'b0;
      wait_neg(s + 1034);
      check("t5_done_early", int'(capture_done), 0);
      wait_neg(s + 1035);
      check("t5_done", int'(capture_done), 1);
      check("t5_trace_end", int'(trace_end), 4);
      wait_neg(s + 1050);
      check("t5_writes_left", exp_q.size(), 0);
      trig2 = 1'b1;

      // start while busy ignored, abort in TRIGGERED, read port, restart
      trig_src = 1'b0;
      trig_edge = 1'b1;
      trig_pos = 9'd10;
      do_start(s);
      push_wr(s, 0, 1, 507);
      wait_neg(s + 101);
      start = 1'b1;
      wait_neg(s + 102);
      start = 1'b0;
      wait_neg(s + 1009);
      force_trig = 1'b1;
      wait_neg(s + 1010);
      force_trig = 1'b0;
      wait_neg(s + 1013);
      abort = 1'b1;
      wait_neg(s + 1014);
      abort = 1'b0;
      check("t6_abort_busy", int'(busy), 0);
      check("t6_abort_en", int'(en), 0);
      check("t6_abort_we", int'(we), 0);
      check("t6_abort_done", int'(capture_done), 0);
      check("t6_trace_end_kept", int'(trace_end), 4);
      rd_en = 1'b1;
      rd_addr = 9'h1A5;
      wait_neg(s + 1015);
      check("t6_rd_en", int'(en), 1);
      check("t6_rd_we", int'(we), 0);
      check("t6_rd_addr", int'(addr), 'h1A5);
      rd_en = 1'b0;
      check("t6_writes_left", exp_q.size(), 0);
      do_start(s);
      push_wr(s, 0, 1, 2);
      check("t6_restart_busy", int'(busy), 1);
      wait_neg(s + 3);
      abort = 1'b1;
      wait_neg(s + 4);
      abort = 1'b0;
      check("t6_restart_abort", int'(busy), 0);
      wait_neg(s + 10);
      check("t6_restart_writes_left", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
